conv_window_fifo: RTL and testbench
===================================

CONV_WINDOW_FIFO -- requirements
Module: conv_window_fifo

Interface
REQ-001 Parameter: DATA_W, 32, sample and coefficient width in bits.
REQ-002 Parameter: DEPTH, 8, sample storage entries; power of two, >= WIN.
REQ-003 Parameter: WIN, 3, window length (kernel taps); 2..DEPTH.
REQ-004 Parameter: STRIDE, 1, samples retired per completed window; 1..WIN.
REQ-005 Port: clk  input  1  sole clock, rising edge.
REQ-006 Port: reset  input  1  asynchronous, active-high reset.
REQ-007 Port: flush  input  1  synchronous clear of stored samples and window position.
REQ-008 Port: in_data  input  DATA_W  sample to store.
REQ-009 Port: in_valid  input  1  in_data valid.
REQ-010 Port: in_ready  output  1  storage can accept a sample this cycle.
REQ-011 Port: out_data  output  DATA_W  registered window sample.
REQ-012 Port: out_valid  output  1  out_data valid.
REQ-013 Port: out_ready  input  1  consumer accepts out_data.
REQ-014 Port: out_last  output  1  out_data is last sample (tap WIN-1) of its window.
REQ-015 Port: level  output  $clog2(DEPTH)+1  stored sample count.

Function
REQ-016 Input handshake: sample written at mem[wr_ptr] on rising edge when in_valid && in_ready; wr_ptr wraps modulo DEPTH.
REQ-017 in_ready = (level < DEPTH) && !flush; combinational from registered state only.
REQ-018 Window: samples mem[base+0..WIN-1], emitted in tap order via offset counter ofs (0..WIN-1); base and ofs wrap modulo DEPTH.
REQ-019 Output register load when (!out_valid || out_ready) && level >= WIN, level sampled before this edge's push; otherwise out_valid clears on out_ready.
REQ-020 Latency: WIN-th sample written at edge N -> out_valid high after edge N+1 at earliest.
REQ-021 Load with ofs==WIN-1: out_last=1, ofs->0, base advances by STRIDE, STRIDE samples freed same edge.
REQ-022 Simultaneous push and retire: level_next = level + push - (retire ? STRIDE : 0); no lost or duplicated sample.
REQ-023 out_valid && !out_ready: out_data, out_last held stable.
REQ-024 Full (level==DEPTH): in_ready low; no write; window emission continues.
REQ-025 Insufficient data (level < WIN): no load; held output register still drains on out_ready.
REQ-026 flush: pointers, ofs, level, out_valid, out_last cleared on that edge; concurrent push dropped; mem contents need not clear.

Reset
REQ-027 reset high: wr_ptr, base, ofs, level, out_valid, out_last, out_data cleared to 0 immediately, no clock required.
REQ-028 in_ready reads 1 while reset low and storage empty; in-flight window discarded on reset mid-operation.
REQ-029 First load permitted on second rising edge after reset deassertion.

Configuration
REQ-030 Macro CONV_WINDOW_FIFO_KBUF_EN defined: adds ports kernel_we (in 1), kernel_idx (in $clog2(WIN)), kernel_in (in DATA_W), kernel_out (out DATA_W).
REQ-031 With macro: WIN-entry coefficient file, written on kernel_we at kernel_idx; kernel_out registered alongside out_data, = coef[ofs] of loaded sample; coefficients reset to 0, unaffected by flush.
REQ-032 Macro undefined: no kernel ports or coefficient storage; all other behaviour identical.

Verification
REQ-033 WIN=3,STRIDE=1, push 1..5, out_ready=1 -> out_data 1,2,3,2,3,4,3,4,5; out_last on 3rd,6th,9th; level ends 2.
REQ-034 WIN=3,STRIDE=3, push 1..6 -> out 1,2,3,4,5,6; level 0 at end; no overlap.
REQ-035 DEPTH=8, out_ready=0, push 10 samples -> in_ready low after 8 accepted; level=8; out_data=1 held stable.
REQ-036 Mid-window (after out 1,2) assert flush with in_valid=1 -> out_valid=0, level=0 next cycle; pushed sample absent from later output.
REQ-037 reset asserted mid-window between edges -> out_valid, level zero before next edge; after release push 7,8,9 -> out 7,8,9.
REQ-038 KBUF_EN, coefs {5,6,7}, push 1..4 -> kernel_out 5,6,7,5,6,7 aligned with out_data 1,2,3,2,3,4.

Source files
------------

// File: rtl/conv_window_fifo.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_fifo
// Brief    : Sample FIFO that replays overlapping WIN-tap windows, retiring
//            STRIDE samples per completed window. Optional coefficient file
//            enabled by CONV_WINDOW_FIFO_KBUF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int WIN    = 3,
    parameter int STRIDE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
`ifdef CONV_WINDOW_FIFO_KBUF_EN
    input  logic                   kernel_we,
    input  logic [$clog2(WIN)-1:0] kernel_idx,
    input  logic [DATA_W-1:0]      kernel_in,
    output logic [DATA_W-1:0]      kernel_out,
`endif
    output logic [$clog2(DEPTH):0] level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_OW = $clog2(WIN);
    localparam int c_LW = c_AW + 1;

    localparam logic [c_LW-1:0] c_DEPTH_L  = c_LW'(DEPTH);
    localparam logic [c_LW-1:0] c_WIN_L    = c_LW'(WIN);
    localparam logic [c_LW-1:0] c_STRIDE_L = c_LW'(STRIDE);
    localparam logic [c_AW-1:0] c_STRIDE_A = c_AW'(STRIDE);
    localparam logic [c_OW-1:0] c_LAST_OFS = c_OW'(WIN - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_base;
    logic [c_OW-1:0]   r_ofs;
    logic [c_LW-1:0]   r_level;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_last;

    logic              w_push;
    logic              w_load;
    logic              w_last_tap;
    logic              w_retire;
    logic [c_AW-1:0]   w_rd_addr;
    logic [c_LW-1:0]   w_level_next;

    assign in_ready     = (r_level < c_DEPTH_L) && !flush;
    assign w_push       = in_valid && in_ready;
    // Level is the pre-push count, so a sample written this edge is never read this edge.
    assign w_load       = (!r_out_valid || out_ready) && (r_level >= c_WIN_L);
    assign w_last_tap   = (r_ofs == c_LAST_OFS);
    assign w_retire     = w_load && w_last_tap;
    assign w_rd_addr    = r_base + c_AW'(r_ofs);
    assign w_level_next = r_level + c_LW'(w_push) - (w_retire ? c_STRIDE_L : '0);

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign level     = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_base      <= '0;
            r_ofs       <= '0;
            r_level     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_base      <= '0;
            r_ofs       <= '0;
            r_level     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            r_level <= w_level_next;
            if (w_load) begin
                r_out_data  <= r_mem[w_rd_addr];
                r_out_valid <= 1'b1;
                r_out_last  <= w_last_tap;
                if (w_last_tap) begin
                    r_ofs  <= '0;
                    r_base <= r_base + c_STRIDE_A;
                end else begin
                    r_ofs <= r_ofs + c_OW'(1);
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef CONV_WINDOW_FIFO_KBUF_EN
    logic [DATA_W-1:0] r_coef [WIN];
    logic [DATA_W-1:0] r_kernel_out;

    assign kernel_out = r_kernel_out;

    // Coefficients survive flush; only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIN; i++) begin
                r_coef[i] <= '0;
            end
            r_kernel_out <= '0;
        end else begin
            if (kernel_we && (int'(kernel_idx) < WIN)) begin
                r_coef[kernel_idx] <= kernel_in;
            end
            if (w_load && !flush) begin
                r_kernel_out <= r_coef[r_ofs];
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_window_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_fifo
// Brief    : Directed self-checking bench for conv_window_fifo (stride 1 and
//            stride 3 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [3:0]  level;

    logic        s_flush;
    logic [31:0] s_in_data;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [31:0] s_out_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic        s_out_last;
    logic [3:0]  s_level;

`ifdef CONV_WINDOW_FIFO_KBUF_EN
    logic        kernel_we;
    logic [1:0]  kernel_idx;
    logic [31:0] kernel_in;
    logic [31:0] kernel_out;
    logic [31:0] s_kernel_out;
    logic [31:0] q_kern [$];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q_data [$];
    logic        q_last [$];
    logic [31:0] q3_data [$];
    logic        q3_last [$];

    logic [31:0] exp_a  [9] = '{32'd1, 32'd2, 32'd3, 32'd2, 32'd3, 32'd4, 32'd3, 32'd4, 32'd5};
    logic [31:0] exp_k  [9] = '{32'd5, 32'd6, 32'd7, 32'd5, 32'd6, 32'd7, 32'd5, 32'd6, 32'd7};

    always #5 clk = ~clk;

    conv_window_fifo #(.DATA_W(32), .DEPTH(8), .WIN(3), .STRIDE(1)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
`ifdef CONV_WINDOW_FIFO_KBUF_EN
        .kernel_we  (kernel_we),
        .kernel_idx (kernel_idx),
        .kernel_in  (kernel_in),
        .kernel_out (kernel_out),
`endif
        .level      (level)
    );

    conv_window_fifo #(.DATA_W(32), .DEPTH(8), .WIN(3), .STRIDE(3)) u_dut_s3 (
        .clk        (clk),
        .reset      (reset),
        .flush      (s_flush),
        .in_data    (s_in_data),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .out_data   (s_out_data),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_last   (s_out_last),
`ifdef CONV_WINDOW_FIFO_KBUF_EN
        .kernel_we  (1'b0),
        .kernel_idx (2'd0),
        .kernel_in  (32'd0),
        .kernel_out (s_kernel_out),
`endif
        .level      (s_level)
    );

    // Each negedge with valid && ready is one accepted transfer at the next posedge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
`ifdef CONV_WINDOW_FIFO_KBUF_EN
            q_kern.push_back(kernel_out);
`endif
        end
        if (s_out_valid && s_out_ready) begin
            q3_data.push_back(s_out_data);
            q3_last.push_back(s_out_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qd(input int i);
        return (i < q_data.size()) ? q_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] ql(input int i);
        return (i < q_last.size()) ? {31'd0, q_last[i]} : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] q3d(input int i);
        return (i < q3_data.size()) ? q3_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] q3l(input int i);
        return (i < q3_last.size()) ? {31'd0, q3_last[i]} : 32'hDEAD_BEEF;
    endfunction

    task automatic push(input logic [31:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        s_flush = 1'b0; s_in_data = '0; s_in_valid = 1'b0; s_out_ready = 1'b0;
`ifdef CONV_WINDOW_FIFO_KBUF_EN
        kernel_we = 1'b0; kernel_idx = '0; kernel_in = '0;
`endif
        #3;
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef CONV_WINDOW_FIFO_KBUF_EN
        for (int i = 0; i < 3; i++) begin
            kernel_we = 1'b1; kernel_idx = 2'(i); kernel_in = 32'(5 + i);
            tick();
        end
        kernel_we = 1'b0;
`endif

        // Stride 1: overlapping windows
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) push(32'(k));
        repeat (12) tick();
        check("s1_count", 32'(q_data.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("s1_data[%0d]", i), qd(i), exp_a[i]);
            check($sformatf("s1_last[%0d]", i), ql(i), (i % 3 == 2) ? 32'd1 : 32'd0);
`ifdef CONV_WINDOW_FIFO_KBUF_EN
            check($sformatf("kbuf[%0d]", i), (i < q_kern.size()) ? q_kern[i] : 32'hDEAD_BEEF, exp_k[i]);
`endif
        end
        check("s1_level_end", {28'd0, level}, 32'd2);
        do_flush();
        check("flush_level", {28'd0, level}, 32'd0);

        // Full with stalled consumer
        out_ready = 1'b0;
        q_data.delete(); q_last.delete();
        for (int k = 1; k <= 10; k++) begin
            in_valid = 1'b1; in_data = 32'(k);
            tick();
            if (k == 7) check("full_ready_k7", {31'd0, in_ready}, 32'd1);
            if (k == 8) begin
                check("full_ready_k8", {31'd0, in_ready}, 32'd0);
                check("full_level_k8", {28'd0, level}, 32'd8);
            end
        end
        in_valid = 1'b0;
        check("full_level", {28'd0, level}, 32'd8);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        check("full_out_held", out_data, 32'd1);
        check("full_last_held", {31'd0, out_last}, 32'd0);
        out_ready = 1'b1;
        repeat (24) tick();
        check("drain_count", 32'(q_data.size()), 32'd18);
        check("drain_d3", qd(3), 32'd2);
        check("drain_last2", ql(2), 32'd1);
        check("drain_d17", qd(17), 32'd8);
        check("drain_level", {28'd0, level}, 32'd2);
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
        do_flush();

        // Flush mid-window with a concurrent push
        q_data.delete(); q_last.delete();
        for (int k = 1; k <= 3; k++) push(32'(k));
        tick();
        check("mid_out1", out_data, 32'd1);
        tick();
        check("mid_out2", out_data, 32'd2);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'd99;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_level", {28'd0, level}, 32'd0);
        q_data.delete(); q_last.delete();
        push(32'd20); push(32'd21); push(32'd22);
        repeat (8) tick();
        check("fl_count", 32'(q_data.size()), 32'd3);
        check("fl_d0", qd(0), 32'd20);
        check("fl_d1", qd(1), 32'd21);
        check("fl_d2", qd(2), 32'd22);
        check("fl_last2", ql(2), 32'd1);
        do_flush();

        // Asynchronous reset mid-window
        for (int k = 1; k <= 3; k++) push(32'(k));
        tick();
        tick();
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        #2;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_level", {28'd0, level}, 32'd0);
        check("arst_out_data", out_data, 32'd0);
        q_data.delete(); q_last.delete();
        tick();
        reset = 1'b0;
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        push(32'd7); push(32'd8); push(32'd9);
        repeat (8) tick();
        check("arst_count", 32'(q_data.size()), 32'd3);
        check("arst_d0", qd(0), 32'd7);
        check("arst_d1", qd(1), 32'd8);
        check("arst_d2", qd(2), 32'd9);
        check("arst_last0", ql(0), 32'd0);
        check("arst_last2", ql(2), 32'd1);

        // Stride 3: non-overlapping windows
        s_out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            s_in_valid = 1'b1; s_in_data = 32'(k);
            tick();
        end
        s_in_valid = 1'b0;
        repeat (10) tick();
        check("s3_count", 32'(q3_data.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("s3_data[%0d]", i), q3d(i), 32'(i + 1));
            check($sformatf("s3_last[%0d]", i), q3l(i), (i % 3 == 2) ? 32'd1 : 32'd0);
        end
        check("s3_level", {28'd0, s_level}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
